// File: rtl/graph_assembly_inst_array.sv
// Multi-channel gather: one small FIFO per input channel feeding a round-robin
// arbiter that fills a single registered output slot with valid/ready handshake.

module graph_assembly_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
      else if (do_pop && !do_push) cnt <= cnt - (AW+1)'(1);
    end
  end
endmodule

module graph_assembly_inst_array #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 2,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic [15:0]               out_count
);
  typedef struct packed {
    logic [CW-1:0]    chan;
    logic [WIDTH-1:0] data;
  } out_word_t;

  logic [CHANNELS-1:0][WIDTH-1:0] rdata;
  logic [CHANNELS-1:0]            full, empty, push, pop;
  logic [CW-1:0]                  rr, grant, cand;
  logic                           any, load;
  out_word_t                      out_q;
  logic                           out_vld;
  logic [15:0]                    cnt_q;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      // Ready comes from registered occupancy only; held low while in reset.
      assign in_ready[c] = rst_n & ~full[c];
      assign push[c]     = in_valid[c] & in_ready[c];

      graph_assembly_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push[c]),
        .pop   (pop[c]),
        .wdata (in_data[c*WIDTH +: WIDTH]),
        .rdata (rdata[c]),
        .full  (full[c]),
        .empty (empty[c])
      );
    end
  endgenerate

  // Round-robin search starting at rr; first non-empty channel wins.
  always_comb begin
    grant = '0;
    cand  = '0;
    any   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = CW'((int'(rr) + i) % CHANNELS);
      if (!any && !empty[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

  assign load = (!out_vld || out_ready) && any;

  always_comb begin
    pop = '0;
    if (load) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= '0;
      out_vld <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (load) begin
        out_vld    <= 1'b1;
        out_q.data <= rdata[grant];
        out_q.chan <= grant;
        rr         <= (grant == CW'(CHANNELS-1)) ? '0 : grant + CW'(1);
      end else if (out_ready) begin
        out_vld <= 1'b0;
      end
      if (out_vld && out_ready) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_valid = out_vld;
  assign out_data  = out_q.data;
  assign out_chan  = out_q.chan;
  assign out_count = cnt_q;
endmodule

// File: tb/tb_graph_assembly_inst_array.sv
// Directed bench for graph_assembly_inst_array at default parameters
// (WIDTH=4, CHANNELS=3, DEPTH=2); expected values are hand-computed.

module tb_graph_assembly_inst_array;
  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic [15:0] out_count;

  int checks;
  int failures;

  graph_assembly_inst_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 3'b000;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_chan",  32'(out_chan),  32'h0);
    chk("rst_out_count", 32'(out_count), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'h7);

    // Fairness: two words per channel, rr starts at 0
    out_ready = 1'b1;
    in_valid  = 3'b111;
    in_data   = {4'd3, 4'd2, 4'd1};
    tick;
    in_data   = {4'd7, 4'd6, 4'd5};
    tick;
    in_valid  = 3'b000;
    chk("fair0_valid", 32'(out_valid), 32'h1);
    chk("fair0_chan",  32'(out_chan),  32'h0);
    chk("fair0_data",  32'(out_data),  32'h1);
    tick; chk("fair1_chan", 32'(out_chan), 32'h1); chk("fair1_data", 32'(out_data), 32'h2);
    tick; chk("fair2_chan", 32'(out_chan), 32'h2); chk("fair2_data", 32'(out_data), 32'h3);
    tick; chk("fair3_chan", 32'(out_chan), 32'h0); chk("fair3_data", 32'(out_data), 32'h5);
    tick; chk("fair4_chan", 32'(out_chan), 32'h1); chk("fair4_data", 32'(out_data), 32'h6);
    tick; chk("fair5_chan", 32'(out_chan), 32'h2); chk("fair5_data", 32'(out_data), 32'h7);
    tick;
    chk("fair_end_valid", 32'(out_valid), 32'h0);
    chk("fair_end_count", 32'(out_count), 32'd6);

    // Single word on ch1: two-cycle latency
    in_valid = 3'b010;
    in_data  = {4'd0, 4'hA, 4'd0};
    tick;
    in_valid = 3'b000;
    chk("single_lat_valid", 32'(out_valid), 32'h0);
    tick;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data",  32'(out_data),  32'hA);
    chk("single_chan",  32'(out_chan),  32'h1);
    chk("single_cnt0",  32'(out_count), 32'd6);
    tick;
    chk("single_cnt1",  32'(out_count), 32'd7);
    chk("single_idle",  32'(out_valid), 32'h0);

    // Backpressure and full FIFO on ch0
    out_ready = 1'b0;
    in_valid  = 3'b001;
    in_data   = {8'h00, 4'h1};
    tick;
    in_data   = {8'h00, 4'h2};
    tick;
    chk("bp_valid",  32'(out_valid),   32'h1);
    chk("bp_data1",  32'(out_data),    32'h1);
    chk("bp_rdy_a",  32'(in_ready[0]), 32'h1);
    in_data   = {8'h00, 4'h3};
    tick;
    chk("bp_full",   32'(in_ready[0]), 32'h0);
    chk("bp_hold_a", 32'(out_data),    32'h1);
    in_data   = {8'h00, 4'hF};
    tick;
    in_valid  = 3'b000;
    chk("bp_hold_b", 32'(out_data),    32'h1);
    chk("bp_chan",   32'(out_chan),    32'h0);
    chk("bp_full_b", 32'(in_ready[0]), 32'h0);
    tick;
    chk("bp_hold_c", 32'(out_data),    32'h1);
    out_ready = 1'b1;
    tick;
    chk("bp_drain2", 32'(out_data),    32'h2);
    chk("bp_rdy_b",  32'(in_ready[0]), 32'h1);
    tick;
    chk("bp_drain3", 32'(out_data),    32'h3);
    tick;
    chk("bp_end_valid", 32'(out_valid), 32'h0);
    chk("bp_end_count", 32'(out_count), 32'd10);

    // Pointer wrap: 10 words streamed through ch2
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 10) ? 3'b100 : 3'b000;
      in_data  = {4'(i + 3), 8'h00};
      tick;
      if (i >= 1 && i <= 10) begin
        chk("wrap_valid", 32'(out_valid), 32'h1);
        chk("wrap_data",  32'(out_data),  32'(i + 2));
        chk("wrap_chan",  32'(out_chan),  32'h2);
      end
    end
    chk("wrap_end_valid", 32'(out_valid), 32'h0);
    chk("wrap_end_count", 32'(out_count), 32'd20);

    // Reset mid-operation with output valid and ch1/ch2 occupied
    out_ready = 1'b0;
    in_valid  = 3'b110;
    in_data   = {4'd5, 4'd4, 4'd0};
    tick;
    in_data   = {4'd7, 4'd6, 4'd0};
    tick;
    in_valid  = 3'b000;
    chk("mid_valid", 32'(out_valid), 32'h1);
    chk("mid_chan",  32'(out_chan),  32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(in_ready),  32'h0);
    chk("mid_rst_count", 32'(out_count), 32'h0);
    chk("mid_rst_data",  32'(out_data),  32'h0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'h7);
    in_valid = 3'b111;
    in_data  = {4'hB, 4'hA, 4'h9};
    tick;
    in_valid = 3'b000;
    chk("post_idle", 32'(out_valid), 32'h0);
    tick;
    chk("post_valid", 32'(out_valid), 32'h1);
    chk("post_chan0", 32'(out_chan),  32'h0);
    chk("post_data0", 32'(out_data),  32'h9);
    out_ready = 1'b1;
    tick;
    chk("post_chan1", 32'(out_chan), 32'h1);
    chk("post_data1", 32'(out_data), 32'hA);
    tick;
    chk("post_chan2", 32'(out_chan), 32'h2);
    chk("post_data2", 32'(out_data), 32'hB);
    tick;
    chk("post_end_valid", 32'(out_valid), 32'h0);
    chk("post_end_count", 32'(out_count), 32'd3);

    // Counter wrap: 65537 transfers from a fresh reset
    rst_n = 1'b0;
    tick;
    rst_n    = 1'b1;
    in_valid = 3'b001;
    in_data  = {8'h00, 4'h5};
    repeat (65537) tick;
    chk("cnt_ffff", 32'(out_count), 32'hFFFF);
    tick;
    chk("cnt_zero", 32'(out_count), 32'h0);
    tick;
    chk("cnt_one",  32'(out_count), 32'h1);
    in_valid = 3'b000;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
